// File: rtl/uart_rx_if.sv
// Core-side port bundle of the 8N1 UART receiver: serial line in, byte/status out.
interface uart_rx_if;
  logic       RX;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       interrupt;

  modport slave  (input RX, rx_ack, output rx_data, rx_valid, frame_err, overrun, interrupt);
  modport master (output RX, rx_ack, input rx_data, rx_valid, frame_err, overrun, interrupt);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronised start detect, mid-bit sampling,
// pending-byte interrupt with sticky overrun cleared by rx_ack.
module uart_rx #(
  parameter int sys_clk = 50000000,
  parameter int baud    = 9600
) (
  input  logic     clock,
  input  logic     Rst,
  uart_rx_if.slave bus
);
  localparam logic [31:0] BIT_CNT  = 32'(sys_clk / baud - 1);
  localparam logic [31:0] HALF_CNT = BIT_CNT >> 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_m, rx_s, rx_prev;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg, data_q;
  logic        valid_q, ferr_q, ovr_q, int_q;

  always_ff @(posedge clock) begin
    if (Rst) begin
      state   <= IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      rx_m    <= bus.RX;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.rx_ack) begin
        int_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      case (state)
        // Edge-only trigger: a line stuck low cannot start a new frame.
        IDLE: if (rx_prev && !rx_s) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF_CNT) begin
          if (rx_s) state <= IDLE;
          else begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end
        end else cnt <= cnt + 32'd1;
        DATA: if (cnt == BIT_CNT) begin
          shreg <= {rx_s, shreg[7:1]};
          cnt   <= '0;
          if (idx == 3'd7) state <= STOP;
          else idx <= idx + 3'd1;
        end else cnt <= cnt + 32'd1;
        // A completing byte overrides a same-cycle ack on interrupt; ack still blocks overrun.
        STOP: if (cnt == BIT_CNT) begin
          cnt   <= '0;
          state <= IDLE;
          if (rx_s) begin
            data_q  <= shreg;
            valid_q <= 1'b1;
            int_q   <= 1'b1;
            if (int_q && !bus.rx_ack) ovr_q <= 1'b1;
          end else ferr_q <= 1'b1;
        end else cnt <= cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.interrupt = int_q;
endmodule
